// File: rtl/alert_level_encoder.sv
// Threat-score to one-hot alert level conditioner: threshold hysteresis,
// consecutive-sample confirmation and a stale-input fail-safe.
module alert_level_encoder #(
  parameter int unsigned YELLOW_TH    = 64,
  parameter int unsigned RED_TH       = 192,
  parameter int unsigned HYST         = 16,
  parameter int unsigned CONFIRM      = 3,
  parameter int unsigned DOWN_CONFIRM = 5,
  parameter int unsigned STALE_LIMIT  = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] threat,
  input  logic       threat_valid,
  output logic       green,
  output logic       yellow,
  output logic       red,
  output logic       level_change,
  output logic       stale,
  output logic [7:0] dwell
);

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2
  } level_t;

  localparam logic [8:0] YEL9  = 9'(YELLOW_TH);
  localparam logic [8:0] RED9  = 9'(RED_TH);
  localparam logic [8:0] HYST9 = 9'(HYST);
  localparam logic [3:0] UP4   = 4'(CONFIRM);
  localparam logic [3:0] DN4   = 4'(DOWN_CONFIRM);
  localparam logic [7:0] LIM8  = 8'(STALE_LIMIT);

  level_t     state, state_nx, cls;
  logic [3:0] up_cnt, dn_cnt, up_nx, dn_nx, up_inc, dn_inc;
  logic [7:0] stale_cnt, stale_nx;
  logic [8:0] score, sum;
  logic       above, below;

  always_comb begin
    score  = {1'b0, threat};
    sum    = score + HYST9;
    if (score >= RED9)      cls = RED;
    else if (score >= YEL9) cls = YELLOW;
    else                    cls = GREEN;
    above  = cls > state;
    below  = ((state == RED) && (sum < RED9)) || ((state == YELLOW) && (sum < YEL9));
    up_inc = up_cnt + 4'd1;
    dn_inc = dn_cnt + 4'd1;

    state_nx = state;
    up_nx    = up_cnt;
    dn_nx    = dn_cnt;
    stale_nx = stale_cnt;

    if (threat_valid) begin
      stale_nx = 8'd0;
      if (above) begin
        dn_nx = 4'd0;
        if (up_inc == UP4) begin
          state_nx = cls;
          up_nx    = 4'd0;
        end else begin
          up_nx = up_inc;
        end
      end else if (below) begin
        up_nx = 4'd0;
        if (dn_inc == DN4) begin
          state_nx = (state == RED) ? YELLOW : GREEN;
          dn_nx    = 4'd0;
        end else begin
          dn_nx = dn_inc;
        end
      end else begin
        up_nx = 4'd0;
        dn_nx = 4'd0;
      end
    end else if (stale_cnt != 8'd255) begin
      stale_nx = stale_cnt + 8'd1;
      // Fail-safe fires only on the increment that lands on the limit.
      if ((stale_nx == LIM8) && (state == GREEN)) begin
        state_nx = YELLOW;
        up_nx    = 4'd0;
        dn_nx    = 4'd0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= GREEN;
      up_cnt       <= 4'd0;
      dn_cnt       <= 4'd0;
      stale_cnt    <= 8'd0;
      green        <= 1'b1;
      yellow       <= 1'b0;
      red          <= 1'b0;
      level_change <= 1'b0;
      stale        <= 1'b0;
      dwell        <= 8'd0;
    end else begin
      state        <= state_nx;
      up_cnt       <= up_nx;
      dn_cnt       <= dn_nx;
      stale_cnt    <= stale_nx;
      green        <= (state_nx == GREEN);
      yellow       <= (state_nx == YELLOW);
      red          <= (state_nx == RED);
      level_change <= (state_nx != state);
      stale        <= (stale_nx >= LIM8);
      if (state_nx != state)  dwell <= 8'd0;
      else if (dwell != 8'd255) dwell <= dwell + 8'd1;
    end
  end

endmodule

// File: tb/tb_alert_level_encoder.sv
// Bench for alert_level_encoder: directed vector table plus randomized
// traffic compared against a level-based reference model.
module tb_alert_level_encoder;

  localparam int YTH = 64, RTH = 192, HY = 16, UPC = 3, DNC = 5, SLIM = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] threat = 8'd0;
  logic       threat_valid = 1'b0;
  logic       green, yellow, red, level_change, stale;
  logic [7:0] dwell;

  always #5 clk = ~clk;

  alert_level_encoder #(
    .YELLOW_TH(YTH), .RED_TH(RTH), .HYST(HY),
    .CONFIRM(UPC), .DOWN_CONFIRM(DNC), .STALE_LIMIT(SLIM)
  ) dut (
    .clock(clk), .reset(reset), .threat(threat), .threat_valid(threat_valid),
    .green(green), .yellow(yellow), .red(red), .level_change(level_change),
    .stale(stale), .dwell(dwell)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: level 0/1/2, plain integer counters.
  int m_lvl = 0, m_up = 0, m_dn = 0, m_st = 0, m_dwell = 0;
  int m_chg = 0, m_stale = 0;

  task automatic model(input bit r, input bit v, input int t);
    int prev, c, lim;
    if (r) begin
      m_lvl = 0; m_up = 0; m_dn = 0; m_st = 0;
      m_dwell = 0; m_chg = 0; m_stale = 0;
      return;
    end
    prev = m_lvl;
    if (v) begin
      m_st = 0;
      c   = (t >= RTH) ? 2 : (t >= YTH) ? 1 : 0;
      lim = (m_lvl == 2) ? RTH : YTH;
      if (c > m_lvl) begin
        m_dn = 0; m_up++;
        if (m_up == UPC) begin m_lvl = c; m_up = 0; end
      end else if (m_lvl > 0 && t + HY < lim) begin
        m_up = 0; m_dn++;
        if (m_dn == DNC) begin m_lvl--; m_dn = 0; end
      end else begin
        m_up = 0; m_dn = 0;
      end
    end else if (m_st < 255) begin
      m_st++;
      if (m_st == SLIM && m_lvl == 0) begin m_lvl = 1; m_up = 0; m_dn = 0; end
    end
    m_chg   = (m_lvl != prev);
    m_dwell = m_chg ? 0 : ((m_dwell < 255) ? m_dwell + 1 : 255);
    m_stale = (m_st >= SLIM);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int onehot_act();
    return {29'd0, red, yellow, green};
  endfunction

  task automatic step(input bit r, input bit v, input logic [7:0] t);
    @(negedge clk);
    reset = r; threat_valid = v; threat = t;
    @(posedge clk);
    model(r, v, int'(t));
    #1;
    chk("model_level", onehot_act(), 1 << m_lvl);
    chk("model_change", int'(level_change), m_chg);
    chk("model_stale", int'(stale), m_stale);
    chk("model_dwell", int'(dwell), m_dwell);
  endtask

  typedef struct {
    bit   rst;
    bit   vld;
    logic [7:0] thr;
    int   lvl;
    int   chg;
    int   stl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit v, input int t, input int l, input int c, input int s);
    vec_t x;
    x.rst = r; x.vld = v; x.thr = 8'(t); x.lvl = l; x.chg = c; x.stl = s;
    vecs.push_back(x);
  endtask

  task automatic add_n(input int n, input bit v, input int t, input int l, input int s);
    for (int i = 0; i < n; i++) add(1'b0, v, t, l, 0, s);
  endtask

  initial begin
    // Upgrade to yellow after 3 samples.
    add(1, 0, 0, 0, 0, 0);
    add_n(2, 1, 100, 0, 0);
    add(0, 1, 100, 1, 1, 0);
    // Direct GREEN->RED jump, in-band hold, 5-sample downgrade.
    add(1, 0, 0, 0, 0, 0);
    add_n(2, 1, 200, 0, 0);
    add(0, 1, 200, 2, 1, 0);
    add(0, 1, 180, 2, 0, 0);
    add_n(4, 1, 170, 2, 0);
    add(0, 1, 170, 1, 1, 0);
    // Hysteresis band holds YELLOW; interrupted run restarts the count.
    add_n(6, 1, 50, 1, 0);
    add_n(4, 1, 40, 1, 0);
    add(0, 1, 50, 1, 0, 0);
    add_n(4, 1, 40, 1, 0);
    add(0, 1, 40, 0, 1, 0);
    // Counters hold across invalid gaps.
    add_n(2, 1, 100, 0, 0);
    add_n(2, 0, 100, 0, 0);
    add(0, 1, 100, 1, 1, 0);
    // Stale fail-safe from GREEN.
    add(1, 0, 0, 0, 0, 0);
    add_n(9, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 1, 0, 1);
    // Up to RED, then stale leaves RED alone; a valid sample clears stale.
    add_n(2, 1, 200, 1, 0);
    add(0, 1, 200, 2, 1, 0);
    add_n(9, 0, 0, 2, 0);
    add(0, 0, 0, 2, 0, 1);
    add(0, 1, 200, 2, 0, 0);
    // Reset mid-confirmation discards partial counts.
    add(1, 0, 0, 0, 0, 0);
    add_n(2, 1, 200, 0, 0);
    add(1, 1, 200, 0, 0, 0);
    add_n(2, 1, 200, 0, 0);
    add(0, 1, 200, 2, 1, 0);
    // Boundary scores: exactly at thresholds.
    add(1, 0, 0, 0, 0, 0);
    add_n(2, 1, 64, 0, 0);
    add(0, 1, 64, 1, 1, 0);
    add_n(5, 1, 48, 1, 0);          // 48+16 = 64, not below
    add_n(2, 1, 192, 1, 0);
    add(0, 1, 192, 2, 1, 0);
    add_n(5, 1, 176, 2, 0);         // 176+16 = 192, not below
    add_n(4, 1, 175, 2, 0);
    add(0, 1, 175, 1, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].vld, vecs[i].thr);
      chk($sformatf("vec%0d_level", i), onehot_act(), 1 << vecs[i].lvl);
      chk($sformatf("vec%0d_change", i), int'(level_change), vecs[i].chg);
      chk($sformatf("vec%0d_stale", i), int'(stale), vecs[i].stl);
    end

    // Reset outputs.
    step(1'b1, 1'b1, 8'd255);
    chk("reset_green", int'(green), 1);
    chk("reset_dwell", int'(dwell), 0);
    chk("reset_change", int'(level_change), 0);

    // Dwell saturates: reach RED then hold for 300 cycles.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'd220);
    chk("dwell_after_change", int'(dwell), 0);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 8'd220);
    chk("dwell_saturated", int'(dwell), 255);
    chk("dwell_red_held", int'(red), 1);

    // Randomized regimes against the model.
    begin
      int base, vprob, t;
      int bases[6] = '{20, 50, 100, 170, 200, 250};
      base = 100; vprob = 90;
      for (int i = 0; i < 4000; i++) begin
        if (i % 16 == 0) begin
          base  = bases[$urandom_range(0, 5)];
          vprob = ($urandom_range(0, 3) == 0) ? 10 : 90;
        end
        t = base + int'($urandom_range(0, 30)) - 15;
        if (t < 0) t = 0;
        if (t > 255) t = 255;
        step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < vprob, 8'(t));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alert_level_encoder.md
# alert_level_encoder

Upstream conditioner for the SCP-079 containment controller. It turns a raw 8-bit threat score, sampled once per clock (1 s period), into the one-hot `green`/`yellow`/`red` alert level the controller consumes. It adds threshold hysteresis, consecutive-sample confirmation and a stale-input fail-safe, so the controller never sees chattering or missing levels.

## Interface
- `YELLOW_TH`, default 64: score at or above which a sample classifies as yellow.
- `RED_TH`, default 192: score at or above which a sample classifies as red. Constraint: `YELLOW_TH < RED_TH`.
- `HYST`, default 16: downgrade hysteresis. Constraint: `HYST <= YELLOW_TH`.
- `CONFIRM`, default 3: consecutive confirming samples needed to upgrade (1..15).
- `DOWN_CONFIRM`, default 5: consecutive confirming samples needed to downgrade (1..15).
- `STALE_LIMIT`, default 10: consecutive invalid cycles before the fail-safe fires (1..255).
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `threat`  in  8  unsigned threat score.
- `threat_valid`  in  1  `threat` is a fresh sample this cycle.
- `green`, `yellow`, `red`  out  1 each  registered one-hot alert level, to the controller.
- `level_change`  out  1  one-cycle pulse, high in the first cycle of a new level.
- `stale`  out  1  no valid sample for `STALE_LIMIT` or more cycles.
- `dwell`  out  8  cycles since the last level change, saturating at 255.

## Operation
- States are GREEN, YELLOW and RED; outputs are one-hot from the state. Exactly one of `green`/`yellow`/`red` is high in every cycle, including reset.
- Sample classification (`cls`): RED if `threat >= RED_TH`; else YELLOW if `threat >= YELLOW_TH`; else GREEN.
- Each valid sample falls into exactly one of three categories:
  - "Above": `cls` is higher than the current state.
  - "Below": in RED, `threat + HYST < RED_TH`; in YELLOW, `threat + HYST < YELLOW_TH`; never in GREEN. The sum is computed 9 bits wide, with no underflow or overflow.
  - "In-band": neither above nor below.
- Counters `up_cnt` and `dn_cnt` are each 4 bits.
  - Above sample: `up_cnt++` and `dn_cnt = 0`.
  - Below sample: `dn_cnt++` and `up_cnt = 0`.
  - In-band sample: both counters cleared.
  - Invalid cycle (`threat_valid = 0`): both counters hold.
- Upgrade: an above sample that brings `up_cnt` to `CONFIRM` moves the state to that sample's `cls`. GREEN may jump straight to RED. Both counters clear.
- Downgrade: a below sample that brings `dn_cnt` to `DOWN_CONFIRM` moves the state down exactly one level (RED->YELLOW, YELLOW->GREEN). Both counters clear.
- Stale handling:
  - `stale_cnt` (8 bits) increments on invalid cycles, saturates at 255, and clears on any valid sample.
  - `stale` = (`stale_cnt >= STALE_LIMIT`).
  - Fail-safe: in the cycle `stale_cnt` reaches `STALE_LIMIT`, a GREEN state is forced to YELLOW and both counters clear. YELLOW and RED are unaffected.
  - The first valid sample clears `stale` and is then processed normally.
- `dwell` clears to 0 on every level change; otherwise it increments, saturating at 255.
- `level_change` is high for exactly the first cycle after any state transition, including a fail-safe transition.

## Timing
- Reset values: `green=1`, `yellow=0`, `red=0`, `level_change=0`, `stale=0`, `dwell=0`. Internal counters are 0 and the state is GREEN.
- Latency: the state updates on the edge that samples the confirming input, so the new level is visible 1 cycle after the confirming sample is presented.
- Reset overrides all inputs in the same cycle. Reset mid-confirmation discards all partial counts.
- Outputs are purely registered; there is no combinational path from `threat` to any output.
- Simultaneous events: a valid sample and the fail-safe cannot coincide. An upgrade takes priority over any pending `dn_cnt` because the counters are mutually exclusive.

## Test plan
- **Upgrade to yellow.** Reset, then `threat=100` valid for 3 cycles. Required: `yellow=1` and `level_change=1` in the cycle after the 3rd sample, `dwell=0`. After 2 samples only, `green` is still 1.
- **Direct jump and downgrade timing.**
  - Three valid samples of `threat=200` from GREEN. Required: `red=1` directly, with no YELLOW cycle.
  - Then `threat=180`, valid. Required: in-band, so RED holds.
  - Then `threat=170` valid for 5 cycles. Required: YELLOW only after the 5th.
- **Hysteresis and counter clearing.**
  - From YELLOW, `threat=50` valid, repeated. Required: in-band (50+16 is not < 64), so YELLOW holds indefinitely.
  - From YELLOW, `threat=40` for 4 cycles, then 1 cycle at 50, then 4 cycles at 40. Required: still YELLOW (the counter cleared); a 5th consecutive 40 gives GREEN.
- **Invalid gaps.** Samples `threat=100` valid, valid, invalid, invalid, valid. Required: YELLOW after the last sample, because counters hold across gaps.
- **Stale fail-safe.** In GREEN, hold `threat_valid=0` for 10 cycles. Required: `stale=1` and a GREEN->YELLOW transition with a `level_change` pulse. In RED, the same stimulus gives `stale=1` with `red` still 1. A valid sample then clears `stale` on the next cycle.
- **Reset and dwell.** Assert `reset` mid-confirmation after 2 red samples. Required: GREEN next cycle with all outputs at reset values. Holding a level for 300 cycles gives `dwell=255`.
